// File: rtl/reg_divider.sv
// reg_divider: multi-cycle restoring unsigned divider that writes the
// quotient then the remainder back through the register-file write port.
module reg_divider #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [ADDR_W-1:0] qAdd,
  input  logic [ADDR_W-1:0] rAdd,
  output logic              busy,
  output logic              done,
  output logic              divByZero,
  output logic [DATA_W-1:0] wbData,
  output logic [ADDR_W-1:0] wbAdd,
  output logic              wbEn
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WB_Q,
    WB_R
  } stateT;

  stateT             state, stateN;
  logic [CNT_W-1:0]  cnt, cntN;
  logic [DATA_W-1:0] dvd, dvdN;
  logic [DATA_W-1:0] rem, remN;
  logic [DATA_W-1:0] quo, quoN;
  logic [DATA_W-1:0] dvsr, dvsrN;
  logic [ADDR_W-1:0] qAddQ, qAddN;
  logic [ADDR_W-1:0] rAddQ, rAddN;
  logic              dz, dzN;
  logic [DATA_W:0]   trial;

  logic              busyN, doneN, dbzN, wbEnN;
  logic [DATA_W-1:0] wbDataN;
  logic [ADDR_W-1:0] wbAddN;

  // Register state, datapath and the pre-computed outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      qAddQ     <= '0;
      rAddQ     <= '0;
      dz        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      wbEn      <= 1'b0;
      wbData    <= '0;
      wbAdd     <= '0;
    end else begin
      state     <= stateN;
      cnt       <= cntN;
      dvd       <= dvdN;
      rem       <= remN;
      quo       <= quoN;
      dvsr      <= dvsrN;
      qAddQ     <= qAddN;
      rAddQ     <= rAddN;
      dz        <= dzN;
      busy      <= busyN;
      done      <= doneN;
      divByZero <= dbzN;
      wbEn      <= wbEnN;
      wbData    <= wbDataN;
      wbAdd     <= wbAddN;
    end
  end

  // Next state, one shift/subtract step, and outputs for the next cycle.
  always_comb begin
    stateN = state;
    cntN   = cnt;
    dvdN   = dvd;
    remN   = rem;
    quoN   = quo;
    dvsrN  = dvsr;
    qAddN  = qAddQ;
    rAddN  = rAddQ;
    dzN    = dz;
    trial  = {rem, dvd[DATA_W-1]};

    unique case (state)
      IDLE: begin
        if (start) begin
          dvsrN = divisor;
          qAddN = qAdd;
          rAddN = rAdd;
          cntN  = '0;
          remN  = '0;
          if (divisor == '0) begin
            quoN   = '1;
            remN   = dividend;
            dvdN   = '0;
            dzN    = 1'b1;
            stateN = WB_Q;
          end else begin
            quoN   = '0;
            dvdN   = dividend;
            dzN    = 1'b0;
            stateN = CALC;
          end
        end
      end
      CALC: begin
        dvdN = {dvd[DATA_W-2:0], 1'b0};
        // Remainder stays below divisor, so the low bits hold the difference.
        if (trial >= {1'b0, dvsr}) begin
          remN = trial[DATA_W-1:0] - dvsr;
          quoN = {quo[DATA_W-2:0], 1'b1};
        end else begin
          remN = trial[DATA_W-1:0];
          quoN = {quo[DATA_W-2:0], 1'b0};
        end
        cntN = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          stateN = WB_Q;
        end
      end
      WB_Q: stateN = WB_R;
      WB_R: stateN = IDLE;
      default: stateN = IDLE;
    endcase

    busyN   = (stateN != IDLE);
    wbEnN   = 1'b0;
    wbDataN = '0;
    wbAddN  = '0;
    doneN   = 1'b0;
    dbzN    = 1'b0;
    if (stateN == WB_Q) begin
      wbEnN   = 1'b1;
      wbAddN  = qAddN;
      wbDataN = quoN;
    end else if (stateN == WB_R) begin
      wbEnN   = 1'b1;
      wbAddN  = rAddN;
      wbDataN = remN;
      doneN   = 1'b1;
      dbzN    = dzN;
    end
  end

endmodule

// File: tb/tb_reg_divider.sv
// tb_reg_divider: random and directed divides against an arithmetic
// reference model, plus literal write-back expectations.
module tb_reg_divider;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic [AW-1:0] qAdd = '0;
  logic [AW-1:0] rAdd = '0;
  logic          busy, done, divByZero, wbEn;
  logic [DW-1:0] wbData;
  logic [AW-1:0] wbAdd;

  int checks = 0;
  int errors = 0;

  reg_divider #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .qAdd(qAdd), .rAdd(rAdd),
    .busy(busy), .done(done), .divByZero(divByZero),
    .wbData(wbData), .wbAdd(wbAdd), .wbEn(wbEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          dn;
    logic          dz;
  } wrT;

  wrT            wrLog[$];
  logic [DW-1:0] regFile [2**AW];
  int            busyCnt = 0;

  // Reference: operation accepted when idle; k counts cycles since accept.
  int            mK = 0;
  int            mLat = 0;
  logic [DW-1:0] mA, mB;
  logic [AW-1:0] mQa, mRa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mK <= 0;
    end else begin
      if (wbEn) begin
        regFile[wbAdd] = wbData;
        wrLog.push_back('{wbAdd, wbData, done, divByZero});
      end
      if (busy) busyCnt++;
      if (mK == 0) begin
        if (start) begin
          mA   <= dividend;
          mB   <= divisor;
          mQa  <= qAdd;
          mRa  <= rAdd;
          mLat <= (divisor == 0) ? 2 : DW + 2;
          mK   <= 1;
        end
      end else if (mK == mLat) begin
        mK <= 0;
      end else begin
        mK <= mK + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    logic [DW-1:0] q, r, eD;
    logic [AW-1:0] eA;
    logic          eB, eE, eDn, eZ;
    q   = (mB == 0) ? '1 : mA / mB;
    r   = (mB == 0) ? mA : mA % mB;
    eB  = (mK != 0);
    eE  = (mK != 0) && (mK >= mLat - 1);
    eDn = (mK != 0) && (mK == mLat);
    eZ  = eDn && (mB == 0);
    eA  = !eE ? '0 : (eDn ? mRa : mQa);
    eD  = !eE ? '0 : (eDn ? r : q);
    checks++;
    if ({busy, wbEn, done, divByZero, wbAdd, wbData} !==
        {eB, eE, eDn, eZ, eA, eD}) begin
      errors++;
      $display("FAIL cycle t=%0t got busy=%b en=%b done=%b dz=%b add=%0d data=%h want busy=%b en=%b done=%b dz=%b add=%0d data=%h",
               $time, busy, wbEn, done, divByZero, wbAdd, wbData,
               eB, eE, eDn, eZ, eA, eD);
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic startOp(logic [DW-1:0] a, logic [DW-1:0] b,
                         logic [AW-1:0] qa, logic [AW-1:0] ra);
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    qAdd     = qa;
    rAdd     = ra;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    qAdd     = AW'($urandom);
    rAdd     = AW'($urandom);
  endtask

  task automatic issue(logic [DW-1:0] a, logic [DW-1:0] b,
                       logic [AW-1:0] qa, logic [AW-1:0] ra, bit noise);
    int lat;
    lat = (b == 0) ? 2 : DW + 2;
    startOp(a, b, qa, ra);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      start    = noise && (i < lat - 1) && ($urandom_range(0, 7) == 0);
      dividend = $urandom;
      divisor  = $urandom_range(0, 1) ? 32'd0 : $urandom;
    end
    start = 1'b0;
  endtask

  task automatic clearLog();
    wrLog.delete();
    busyCnt = 0;
  endtask

  initial begin
    #2;
    check("reset busy", 64'(busy), 64'd0);
    check("reset outs", 64'({wbEn, done, divByZero, wbAdd, wbData}), 64'd0);
    #10 rst_n = 1'b1;

    clearLog();
    issue(100, 7, 3, 4, 0);
    check("100/7 writes", 64'(wrLog.size()), 64'd2);
    if (wrLog.size() == 2) begin
      check("100/7 qAdd", 64'(wrLog[0].a), 64'd3);
      check("100/7 q", 64'(wrLog[0].d), 64'd14);
      check("100/7 rAdd", 64'(wrLog[1].a), 64'd4);
      check("100/7 r", 64'(wrLog[1].d), 64'd2);
      check("100/7 done", 64'({wrLog[0].dn, wrLog[1].dn, wrLog[1].dz}), 64'b010);
    end
    check("100/7 busy cycles", 64'(busyCnt), 64'd34);

    clearLog();
    issue(32'hFFFF_FFFF, 1, 1, 2, 0);
    issue(5, 32'hFFFF_FFFF, 1, 2, 0);
    check("max writes", 64'(wrLog.size()), 64'd4);
    if (wrLog.size() == 4) begin
      check("max/1 q", 64'(wrLog[0].d), 64'hFFFF_FFFF);
      check("max/1 r", 64'(wrLog[1].d), 64'd0);
      check("5/max q", 64'(wrLog[2].d), 64'd0);
      check("5/max r", 64'(wrLog[3].d), 64'd5);
    end
    check("max busy cycles", 64'(busyCnt), 64'd68);

    clearLog();
    issue(1234, 0, 6, 7, 0);
    check("dz writes", 64'(wrLog.size()), 64'd2);
    if (wrLog.size() == 2) begin
      check("dz q", 64'({wrLog[0].a, wrLog[0].d}), {27'd0, 5'd6, 32'hFFFF_FFFF});
      check("dz r", 64'({wrLog[1].a, wrLog[1].d}), {27'd0, 5'd7, 32'd1234});
      check("dz flag", 64'({wrLog[1].dn, wrLog[1].dz}), 64'b11);
    end
    check("dz busy cycles", 64'(busyCnt), 64'd2);

    clearLog();
    startOp(50, 5, 10, 11);
    repeat (8) @(posedge clk);
    #1;
    dividend = 9;
    divisor  = 3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    check("ignore writes", 64'(wrLog.size()), 64'd2);
    if (wrLog.size() == 2) begin
      check("ignore q", 64'(wrLog[0].d), 64'd10);
      check("ignore r", 64'(wrLog[1].d), 64'd0);
    end

    clearLog();
    startOp(1000, 3, 12, 13);
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort outs", 64'({wbEn, done, divByZero, wbAdd, wbData}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    check("abort no wb", 64'(wrLog.size()), 64'd0);
    issue(9, 4, 14, 15, 0);
    check("after abort writes", 64'(wrLog.size()), 64'd2);
    if (wrLog.size() == 2) begin
      check("9/4 q", 64'(wrLog[0].d), 64'd2);
      check("9/4 r", 64'(wrLog[1].d), 64'd1);
    end

    clearLog();
    issue(17, 5, 9, 9, 0);
    check("same-reg writes", 64'(wrLog.size()), 64'd2);
    if (wrLog.size() == 2) begin
      check("same-reg first", 64'({wrLog[0].a, wrLog[0].d}), {27'd0, 5'd9, 32'd3});
      check("same-reg second", 64'({wrLog[1].a, wrLog[1].d}), {27'd0, 5'd9, 32'd2});
    end
    check("reg9 final", 64'(regFile[9]), 64'd2);

    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 20);
        2: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      issue(a, b, AW'($urandom), AW'($urandom), 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
